serial_adder_ctrl: RTL and testbench

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/full_adder_1bit.sv | 13 +
 rtl/full_adder_2bit.sv | 28 ++
 rtl/serial_adder_ctrl.sv | 103 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the serial adder controller.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder_1bit.sv
// Single-bit full adder cell.
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/full_adder_2bit.sv
// Two-bit ripple slice built from two full_adder_1bit cells.
module full_adder_2bit (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       ci,
  output logic [1:0] s,
  output logic       co
);

  logic c_mid;

  full_adder_1bit u_bit0 (
    .a  (a[0]),
    .b  (b[0]),
    .ci (ci),
    .s  (s[0]),
    .co (c_mid)
  );

  full_adder_1bit u_bit1 (
    .a  (a[1]),
    .b  (b[1]),
    .ci (c_mid),
    .s  (s[1]),
    .co (co)
  );

endmodule

// File: rtl/serial_adder_ctrl.sv
// Serial adder: one shared 2-bit slice walks the operands LSB first,
// producing {cout,sum} = a + b + cin after WIDTH/2 RUN cycles.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int SLICES = WIDTH / 2;
  localparam int CNT_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SLICES - 1);

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic [CNT_W:0]   base;
  logic [1:0]       sl_a;
  logic [1:0]       sl_b;
  logic [1:0]       sl_s;
  logic             sl_co;

  // Slice select: bit offset of slice cnt is 2*cnt.
  assign base = {cnt, 1'b0};
  assign sl_a = op_a[base +: 2];
  assign sl_b = op_b[base +: 2];

  full_adder_2bit u_slice (
    .a  (sl_a),
    .b  (sl_b),
    .ci (carry),
    .s  (sl_s),
    .co (sl_co)
  );

  // NOTE: all state here is registered with non-blocking assignments so every
  // register samples pre-edge values; blocking would chain updates within one edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_a  <= a;
            op_b  <= b;
            carry <= cin;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          sum[base +: 2] <= sl_s;
          carry          <= sl_co;
          // Counter holds on the last slice so it never wraps while busy.
          if (cnt == LAST) begin
            cout  <= sl_co;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks of serial_adder_ctrl at WIDTH=8.
module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  // Runs one addition and reports what was seen; n=0 is the sample just after
  // the accepting edge, so done is expected at n=4 (the 5th cycle counting the
  // start cycle). Inputs are scrambled after capture to prove they are ignored.
  task automatic run_op(input logic [7:0] op_a, input logic [7:0] op_b, input logic op_c,
                        output logic [7:0] s_done, output logic c_done,
                        output logic [7:0] s_end, output logic c_end,
                        output int lat, output int busy_cnt, output int done_cnt);
    @(negedge clk);
    a = op_a; b = op_b; cin = op_c; start = 1'b1;
    lat = -1; busy_cnt = 0; done_cnt = 0; s_done = '0; c_done = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; a = ~op_a; b = ~op_b; cin = ~op_c;
    for (int n = 0; n <= 8; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
      end
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        if (lat < 0) begin
          lat = n; s_done = sum; c_done = cout;
        end
      end
    end
    s_end = sum; c_end = cout;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, cout, sum} !== 11'd0) begin
      errors++;
      $display("FAIL reset_async: got busy=%b done=%b cout=%b sum=%h, want all 0", busy, done, cout, sum);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, cout, sum} !== 11'd0) begin
      errors++;
      $display("FAIL reset_held: got busy=%b done=%b cout=%b sum=%h, want all 0", busy, done, cout, sum);
    end
    @(negedge clk) reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] s;
    logic       co;
  } vec_t;

  task automatic test_vectors();
    vec_t vecs[4];
    logic [7:0] s_done, s_end;
    logic c_done, c_end;
    int lat, busy_cnt, done_cnt;
    vecs[0] = '{8'h5A, 8'hA5, 1'b0, 8'hFF, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    for (int i = 0; i < 4; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].c, s_done, c_done, s_end, c_end, lat, busy_cnt, done_cnt);
      checks++;
      if ({c_done, s_done} !== {vecs[i].co, vecs[i].s}) begin
        errors++;
        $display("FAIL vec%0d_result: got cout=%b sum=%h, want cout=%b sum=%h",
                 i, c_done, s_done, vecs[i].co, vecs[i].s);
      end
      checks++;
      if (lat !== 4) begin
        errors++;
        $display("FAIL vec%0d_latency: got %0d, want 4", i, lat);
      end
      checks++;
      if (busy_cnt !== 4 || done_cnt !== 1) begin
        errors++;
        $display("FAIL vec%0d_handshake: got busy_cycles=%0d done_pulses=%0d, want 4 1", i, busy_cnt, done_cnt);
      end
      checks++;
      if ({c_end, s_end} !== {vecs[i].co, vecs[i].s}) begin
        errors++;
        $display("FAIL vec%0d_hold: got cout=%b sum=%h, want cout=%b sum=%h",
                 i, c_end, s_end, vecs[i].co, vecs[i].s);
      end
    end
  endtask

  task automatic test_ignore_start();
    int done_cnt = 0, busy_cnt = 0, lat = -1;
    logic [7:0] s_done = '0;
    logic c_done = 1'b0;
    @(negedge clk);
    a = 8'h5A; b = 8'hA5; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n <= 9; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
      end
      if (n == 1) begin
        start = 1'b1; a = 8'h11; b = 8'h11; cin = 1'b1;
      end
      if (n == 2) start = 1'b0;
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        if (lat < 0) begin
          lat = n; s_done = sum; c_done = cout;
        end
      end
    end
    checks++;
    if ({c_done, s_done} !== 9'h0FF) begin
      errors++;
      $display("FAIL ignore_start_result: got cout=%b sum=%h, want cout=0 sum=ff", c_done, s_done);
    end
    checks++;
    if (done_cnt !== 1 || lat !== 4 || busy_cnt !== 4) begin
      errors++;
      $display("FAIL ignore_start_pulses: got done_pulses=%0d lat=%0d busy_cycles=%0d, want 1 4 4",
               done_cnt, lat, busy_cnt);
    end
  endtask

  task automatic test_start_held();
    logic [9:0] busy_trace = '0;
    int done_cnt = 0;
    @(negedge clk);
    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    for (int n = 0; n <= 9; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
      end
      busy_trace[n] = busy;
      if (done === 1'b1) done_cnt++;
    end
    start = 1'b0;
    // Busy n=0..3, done n=4, IDLE n=5, re-accepted at edge n=6.
    checks++;
    if (busy_trace !== 10'b11_1100_1111) begin
      errors++;
      $display("FAIL start_held_busy: got %b, want 1111001111", busy_trace);
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL start_held_done: got %0d pulses, want 1", done_cnt);
    end
    checks++;
    if (sum !== 8'h03) begin
      errors++;
      $display("FAIL start_held_sum: got %h, want 03", sum);
    end
    repeat (8) @(posedge clk);
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] s_done, s_end;
    logic c_done, c_end;
    int lat, busy_cnt, done_cnt = 0, busy_after = 0;
    @(negedge clk);
    a = 8'h5A; b = 8'hA5; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sum !== 8'h0F || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_run_partial: got sum=%h busy=%b, want sum=0f busy=1", sum, busy);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, cout, sum} !== 11'd0) begin
      errors++;
      $display("FAIL mid_run_reset: got busy=%b done=%b cout=%b sum=%h, want all 0", busy, done, cout, sum);
    end
    @(negedge clk) reset = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_cnt++;
      if (busy === 1'b1) busy_after++;
    end
    checks++;
    if (done_cnt !== 0 || busy_after !== 0) begin
      errors++;
      $display("FAIL mid_run_abort: got done_pulses=%0d busy_cycles=%0d, want 0 0", done_cnt, busy_after);
    end
    run_op(8'h12, 8'h34, 1'b0, s_done, c_done, s_end, c_end, lat, busy_cnt, done_cnt);
    checks++;
    if ({c_done, s_done} !== 9'h046 || lat !== 4) begin
      errors++;
      $display("FAIL after_reset_op: got cout=%b sum=%h lat=%0d, want cout=0 sum=46 lat=4", c_done, s_done, lat);
    end
  endtask

  task automatic test_random();
    logic [7:0] ra, rb, s_done, s_end;
    logic rc, c_done, c_end;
    logic [8:0] ref_sum;
    int lat, busy_cnt, done_cnt;
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      ref_sum = 9'(ra) + 9'(rb) + 9'(rc);
      run_op(ra, rb, rc, s_done, c_done, s_end, c_end, lat, busy_cnt, done_cnt);
      checks++;
      if ({c_done, s_done} !== ref_sum) begin
        errors++;
        $display("FAIL rand%0d_result: %h+%h+%b got %h, want %h", i, ra, rb, rc, {c_done, s_done}, ref_sum);
      end
      checks++;
      if (lat !== 4 || done_cnt !== 1) begin
        errors++;
        $display("FAIL rand%0d_timing: got lat=%0d done_pulses=%0d, want 4 1", i, lat, done_cnt);
      end
      checks++;
      if ({c_end, s_end} !== ref_sum) begin
        errors++;
        $display("FAIL rand%0d_hold: got %h, want %h", i, {c_end, s_end}, ref_sum);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_ignore_start();
    test_start_held();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
